bus_mux_arbiter: RTL and testbench

//   Shares one WIDTH-bit 2:1 bus multiplexer between two requesters.

---
 rtl/bus_mux_arbiter.sv | 131 +++++++++++++
 tb/tb_bus_mux_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/bus_mux_arbiter.sv
// Round-robin 2:1 bus mux arbiter with burst limit; optional beat counters under BUS_ARB_STATS_EN.
// Latency: grant 1 cycle after request; datapath combinational while owning.
// Backpressure: i_out_ready=0 holds state, select and burst count; no ack is issued.
module bus_mux_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4
`ifdef BUS_ARB_STATS_EN
  , parameter int CNT_W   = 8
`endif
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req_0,
  input  logic [WIDTH-1:0] i_data_0,
  input  logic             i_last_0,
  output logic             o_gnt_0,
  output logic             o_ack_0,
  input  logic             i_req_1,
  input  logic [WIDTH-1:0] i_data_1,
  input  logic             i_last_1,
  output logic             o_gnt_1,
  output logic             o_ack_1,
  output logic             o_sel,
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_out_data,
  input  logic             i_out_ready
`ifdef BUS_ARB_STATS_EN
  , output logic [CNT_W-1:0] o_beats_0
  , output logic [CNT_W-1:0] o_beats_1
`endif
);

  localparam int BW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [BW:0] LP_MAX = (BW + 1)'(MAX_BURST);

  typedef enum logic [1:0] {S_IDLE, S_OWN0, S_OWN1} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_prio, w_prio_nxt;
  logic [BW-1:0] r_burst_cnt, w_burst_nxt;

  logic          w_owning, w_owner, w_own_req, w_own_last, w_oth_req;
  logic          w_valid, w_beat, w_release;
  logic [BW:0]   w_cnt_inc;

  always_comb begin
    w_owning   = (r_state != S_IDLE);
    w_owner    = (r_state == S_OWN1);
    w_own_req  = w_owner ? i_req_1  : i_req_0;
    w_own_last = w_owner ? i_last_1 : i_last_0;
    w_oth_req  = w_owner ? i_req_0  : i_req_1;
    w_valid    = w_owning & w_own_req;
    w_beat     = w_valid & i_out_ready;
    w_cnt_inc  = {1'b0, r_burst_cnt} + (BW + 1)'(1);
    // >= rather than == so a saturated counter still yields once the other side asks
    w_release  = w_owning & (~w_own_req
                           | (w_beat & w_own_last)
                           | (w_beat & (w_cnt_inc >= LP_MAX) & w_oth_req));
  end

  assign o_gnt_0     = (r_state == S_OWN0);
  assign o_gnt_1     = (r_state == S_OWN1);
  assign o_sel       = w_owner;
  assign o_out_valid = w_valid;
  assign o_out_data  = w_valid ? (w_owner ? i_data_1 : i_data_0) : '0;
  assign o_ack_0     = w_beat & ~w_owner;
  assign o_ack_1     = w_beat & w_owner;

  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    w_burst_nxt = r_burst_cnt;
    case (r_state)
      S_IDLE: begin
        w_burst_nxt = '0;
        if (i_req_0 && (!i_req_1 || !r_prio)) begin
          w_state_nxt = S_OWN0;
        end else if (i_req_1) begin
          w_state_nxt = S_OWN1;
        end
      end
      S_OWN0, S_OWN1: begin
        if (w_release) begin
          w_prio_nxt  = ~w_owner;
          w_burst_nxt = '0;
          if (w_oth_req) begin
            w_state_nxt = w_owner ? S_OWN0 : S_OWN1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (w_beat) begin
          w_burst_nxt = (w_cnt_inc >= LP_MAX) ? LP_MAX[BW-1:0] : w_cnt_inc[BW-1:0];
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_burst_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_prio      <= 1'b0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_prio      <= w_prio_nxt;
      r_burst_cnt <= w_burst_nxt;
    end
  end

`ifdef BUS_ARB_STATS_EN
  logic [CNT_W-1:0] r_beats_0, r_beats_1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_beats_0 <= '0;
      r_beats_1 <= '0;
    end else begin
      if (o_ack_0 && (r_beats_0 != '1)) r_beats_0 <= r_beats_0 + CNT_W'(1);
      if (o_ack_1 && (r_beats_1 != '1)) r_beats_1 <= r_beats_1 + CNT_W'(1);
    end
  end

  assign o_beats_0 = r_beats_0;
  assign o_beats_1 = r_beats_1;
`endif

endmodule

// File: tb/tb_bus_mux_arbiter.sv
// Directed bench for bus_mux_arbiter: vector table plus hand sequences for stall, reset and saturation.
module tb_bus_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_0, last_0, req_1, last_1, out_ready;
  logic [3:0] data_0, data_1;
  logic       gnt_0, ack_0, gnt_1, ack_1, sel, out_valid;
  logic [3:0] out_data;
`ifdef BUS_ARB_STATS_EN
  logic [1:0] beats_0, beats_1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef BUS_ARB_STATS_EN
  bus_mux_arbiter #(.WIDTH(4), .MAX_BURST(4), .CNT_W(2)) dut (
`else
  bus_mux_arbiter #(.WIDTH(4), .MAX_BURST(4)) dut (
`endif
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_0(req_0), .i_data_0(data_0), .i_last_0(last_0), .o_gnt_0(gnt_0), .o_ack_0(ack_0),
    .i_req_1(req_1), .i_data_1(data_1), .i_last_1(last_1), .o_gnt_1(gnt_1), .o_ack_1(ack_1),
    .o_sel(sel), .o_out_valid(out_valid), .o_out_data(out_data), .i_out_ready(out_ready)
`ifdef BUS_ARB_STATS_EN
    , .o_beats_0(beats_0), .o_beats_1(beats_1)
`endif
  );

  typedef struct packed {
    logic       rst_n, r0;
    logic [3:0] d0;
    logic       l0, r1;
    logic [3:0] d1;
    logic       l1, rdy;
    logic       g0, g1, sl, vl;
    logic [3:0] dat;
    logic       a0, a1;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rn, r0, input logic [3:0] d0, input logic l0, r1,
                     input logic [3:0] d1, input logic l1, rdy, g0, g1, sl, vl,
                     input logic [3:0] dat, input logic a0, a1);
    vec_t v;
    v = '{rn, r0, d0, l0, r1, d1, l1, rdy, g0, g1, sl, vl, dat, a0, a1};
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge.
  task automatic step(input logic rn, r0, input logic [3:0] d0, input logic l0, r1,
                      input logic [3:0] d1, input logic l1, rdy);
    @(posedge clk);
    #1;
    rst_n = rn; req_0 = r0; data_0 = d0; last_0 = l0;
    req_1 = r1; data_1 = d1; last_1 = l1; out_ready = rdy;
  endtask

  // Compare outputs on the falling edge of the current cycle.
  task automatic expect_out(input string tag, input logic g0, g1, sl, vl,
                            input logic [3:0] dat, input logic a0, a1);
    @(negedge clk);
    chk({tag, ".gnt_0"},     32'(gnt_0),     32'(g0));
    chk({tag, ".gnt_1"},     32'(gnt_1),     32'(g1));
    chk({tag, ".sel"},       32'(sel),       32'(sl));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(vl));
    chk({tag, ".out_data"},  32'(out_data),  32'(dat));
    chk({tag, ".ack_0"},     32'(ack_0),     32'(a0));
    chk({tag, ".ack_1"},     32'(ack_1),     32'(a1));
  endtask

  initial begin
    rst_n = 1'b0; req_0 = 1'b0; data_0 = '0; last_0 = 1'b0;
    req_1 = 1'b0; data_1 = '0; last_1 = 1'b0; out_ready = 1'b0;

    // rn r0 d0 l0 r1 d1 l1 rdy | g0 g1 sl vl dat a0 a1
    add(0, 0, 4'h0, 0, 0, 4'h0, 0, 0,  0, 0, 0, 0, 4'h0, 0, 0);   // reset state
    add(1, 1, 4'h3, 1, 0, 4'h0, 0, 1,  0, 0, 0, 0, 4'h0, 0, 0);   // single beat: request seen
    add(1, 1, 4'h3, 1, 0, 4'h0, 0, 1,  1, 0, 0, 1, 4'h3, 1, 0);   // granted, acked, last
    add(1, 0, 4'h0, 0, 0, 4'h0, 0, 1,  0, 0, 0, 0, 4'h0, 0, 0);   // back to idle
    add(0, 0, 4'h0, 0, 0, 4'h0, 0, 0,  0, 0, 0, 0, 4'h0, 0, 0);   // reset restores prio 0
    add(1, 1, 4'h5, 0, 1, 4'hA, 0, 1,  0, 0, 0, 0, 4'h0, 0, 0);   // tie
    add(1, 1, 4'h5, 0, 1, 4'hA, 0, 1,  1, 0, 0, 1, 4'h5, 1, 0);   // 0 wins tie
    add(1, 1, 4'h6, 1, 1, 4'hA, 0, 1,  1, 0, 0, 1, 4'h6, 1, 0);   // last_0
    add(1, 0, 4'h0, 0, 1, 4'hA, 1, 1,  0, 1, 1, 1, 4'hA, 0, 1);   // handover, no bubble
    add(1, 0, 4'h0, 0, 0, 4'h0, 0, 1,  0, 0, 0, 0, 4'h0, 0, 0);
    add(1, 1, 4'h1, 0, 1, 4'h2, 0, 1,  0, 0, 0, 0, 4'h0, 0, 0);   // continuous contention
    for (int i = 0; i < 4; i++) add(1, 1, 4'h1, 0, 1, 4'h2, 0, 1,  1, 0, 0, 1, 4'h1, 1, 0);
    for (int i = 0; i < 4; i++) add(1, 1, 4'h1, 0, 1, 4'h2, 0, 1,  0, 1, 1, 1, 4'h2, 0, 1);
    add(1, 1, 4'h1, 0, 1, 4'h2, 0, 1,  1, 0, 0, 1, 4'h1, 1, 0);
    add(1, 0, 4'h0, 0, 0, 4'h0, 0, 1,  1, 0, 0, 0, 4'h0, 0, 0);   // owner withdraws
    add(1, 0, 4'h0, 0, 0, 4'h0, 0, 1,  0, 0, 0, 0, 4'h0, 0, 0);

    repeat (2) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].r0, vecs[i].d0, vecs[i].l0,
           vecs[i].r1, vecs[i].d1, vecs[i].l1, vecs[i].rdy);
      expect_out($sformatf("vec%0d", i), vecs[i].g0, vecs[i].g1, vecs[i].sl,
                 vecs[i].vl, vecs[i].dat, vecs[i].a0, vecs[i].a1);
    end

    // Stall mid-burst: count must hold so the grant still yields after 4 beats.
    step(0, 0, 4'h0, 0, 0, 4'h0, 0, 0); expect_out("stall_rst", 0, 0, 0, 0, 4'h0, 0, 0);
    step(1, 1, 4'h7, 0, 1, 4'h9, 0, 1); expect_out("stall_req", 0, 0, 0, 0, 4'h0, 0, 0);
    step(1, 1, 4'h7, 0, 1, 4'h9, 0, 1); expect_out("stall_b1", 1, 0, 0, 1, 4'h7, 1, 0);
    step(1, 1, 4'h7, 0, 1, 4'h9, 0, 1); expect_out("stall_b2", 1, 0, 0, 1, 4'h7, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 4'h7, 0, 1, 4'h9, 0, 0);
      expect_out($sformatf("stall_hold%0d", i), 1, 0, 0, 1, 4'h7, 0, 0);
    end
    step(1, 1, 4'h7, 0, 1, 4'h9, 0, 1); expect_out("stall_b3", 1, 0, 0, 1, 4'h7, 1, 0);
    step(1, 1, 4'h7, 0, 1, 4'h9, 0, 1); expect_out("stall_b4", 1, 0, 0, 1, 4'h7, 1, 0);
    step(1, 1, 4'h7, 0, 1, 4'h9, 0, 1); expect_out("stall_sw", 0, 1, 1, 1, 4'h9, 0, 1);

    // Reset with requester 1 mid-burst and prio pointing at 1.
    step(1, 1, 4'h7, 0, 1, 4'h9, 0, 1); expect_out("mrst_b2", 0, 1, 1, 1, 4'h9, 0, 1);
    step(0, 1, 4'h7, 0, 1, 4'h9, 0, 1); expect_out("mrst_now", 0, 0, 0, 0, 4'h0, 0, 0);
    step(1, 1, 4'h7, 0, 1, 4'h9, 0, 1); expect_out("mrst_idle", 0, 0, 0, 0, 4'h0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 4'h7, 0, 1, 4'h9, 0, 1);
      expect_out($sformatf("mrst_own0_%0d", i), 1, 0, 0, 1, 4'h7, 1, 0);
    end
    step(1, 1, 4'h7, 0, 1, 4'h9, 0, 1); expect_out("mrst_own1", 0, 1, 1, 1, 4'h9, 0, 1);

    // Lone requester 1: keeps ownership past MAX_BURST.
    step(0, 0, 4'h0, 0, 0, 4'h0, 0, 0); expect_out("solo_rst", 0, 0, 0, 0, 4'h0, 0, 0);
`ifdef BUS_ARB_STATS_EN
    chk("beats_0_rst", 32'(beats_0), 32'd0);
    chk("beats_1_rst", 32'(beats_1), 32'd0);
`endif
    step(1, 0, 4'h0, 0, 1, 4'hC, 0, 1); expect_out("solo_req", 0, 0, 0, 0, 4'h0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 4'h0, 0, 1, 4'hC, 0, 1);
      expect_out($sformatf("solo_b%0d", i), 0, 1, 1, 1, 4'hC, 0, 1);
`ifdef BUS_ARB_STATS_EN
      if (i == 2) chk("beats_1_mid", 32'(beats_1), 32'd2);
`endif
    end
    step(1, 0, 4'h0, 0, 0, 4'h0, 0, 1); expect_out("solo_drop", 0, 1, 1, 0, 4'h0, 0, 0);
`ifdef BUS_ARB_STATS_EN
    chk("beats_1_sat", 32'(beats_1), 32'd3);
    chk("beats_0_zero", 32'(beats_0), 32'd0);
`endif
    step(1, 0, 4'h0, 0, 0, 4'h0, 0, 1); expect_out("solo_idle", 0, 0, 0, 0, 4'h0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
